// File: rtl/uart_fifo.sv
// Synchronous FIFO for the UART loop datapath: 1R/1W RAM, extra-bit pointers, registered read.
// Optional sticky ovf/unf flags are built only when UART_FIFO_FLAGS_EN is defined.
module uart_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              unf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              push_ok;
  logic              pop_ok;

  // The extra MSB tells a wrapped-full pointer pair apart from an empty one.
  assign full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage is not reset; a write during reset is suppressed so the word is discarded.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop_ok;
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr[ADDR_W-1:0]];
      end
    end
  end

`ifdef UART_FIFO_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && full) begin
        ovf <= 1'b1;
      end
      if (pop && empty) begin
        unf <= 1'b1;
      end
    end
  end
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule
